// File: rtl/toy_env_arb.sv
// Round-robin arbiter sharing the toy environment slave port between NUM_REQ requesters.
// Optional TOY_ENV_ARB_PERF_EN adds per-requester grant counters and a stall counter.
module toy_env_arb #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_vld,
  output logic [NUM_REQ-1:0]               req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_wr_en,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wr_byte_en,
  output logic [NUM_REQ-1:0]               rsp_vld,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             en,
  output logic [ADDR_WIDTH-1:0]            addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH/8-1:0]          wr_byte_en,
  output logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             halted
`ifdef TOY_ENV_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]            perf_grant_cnt,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     owner_q;
  logic                   hs;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [BE_W-1:0]        sel_be;
  logic                   sel_wr;
  logic                   exit_hit;

  // Search positions rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first valid requester wins.
  always_comb begin : arb
    logic        found;
    int unsigned idx;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    if (state_q == RUN) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!found && (i == idx) && req_vld[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            rr_ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
          end
        end
      end
    end
  end

  assign req_rdy = grant;
  assign hs      = |(req_vld & grant);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_be   = '0;
    sel_wr   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be   = req_wr_byte_en[i*BE_W +: BE_W];
        sel_wr   = req_wr_en[i];
      end
    end
  end

  // Exit window is 0x000-0x3FF: every address bit above bit 9 must be clear.
  assign exit_hit = sel_wr && ((sel_addr >> 10) == '0) && sel_data[0];

  always_comb begin
    state_d = state_q;
    if ((state_q == RUN) && hs && exit_hit) state_d = HALT;
  end

  assign halted = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      en         <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      wr_byte_en <= '0;
      wr_en      <= 1'b0;
      owner_q    <= '0;
      rsp_vld    <= '0;
      rsp_data   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      en       <= hs;
      if (hs) begin
        addr       <= sel_addr;
        wr_data    <= sel_data;
        wr_byte_en <= sel_be;
        wr_en      <= sel_wr;
        owner_q    <= grant;
      end
      rsp_vld  <= en ? owner_q : '0;
      rsp_data <= (en && !wr_en) ? rd_data : '0;
    end
  end

`ifdef TOY_ENV_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && req_vld[i] && (perf_grant_cnt[i*32 +: 32] != '1))
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|(req_vld & ~grant)) && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_toy_env_arb.sv
// Randomized self-checking bench for toy_env_arb against a cycle-level transaction model.
module tb_toy_env_arb;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_rdy;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_wr_en;
  logic [N*DW-1:0]   req_wr_data;
  logic [N*BW-1:0]   req_wr_byte_en;
  logic [N-1:0]      rsp_vld;
  logic [DW-1:0]     rsp_data;
  logic              en;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wr_data;
  logic [BW-1:0]     wr_byte_en;
  logic              wr_en;
  logic [DW-1:0]     rd_data;
  logic              halted;

  always #5 clk = ~clk;

  toy_env_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_wr_byte_en(req_wr_byte_en),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .en(en), .addr(addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en), .wr_en(wr_en),
    .rd_data(rd_data), .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side staging (what each requester presents next cycle)
  logic          s_vld  [N];
  logic [AW-1:0] s_addr [N];
  logic          s_wr   [N];
  logic [DW-1:0] s_data [N];
  logic [BW-1:0] s_be   [N];
  logic [N-1:0]  pend;
  bit            allow_exit;

  // Reference model: expected slave-port and response state after the coming edge
  int            m_ptr;
  bit            m_halt;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_be;
  int            m_own;
  logic [N-1:0]  m_rsp;
  logic [DW-1:0] m_rsp_data;

  task automatic model_reset();
    m_ptr = 0; m_halt = 0; m_en = 0; m_addr = '0; m_wr = 0; m_data = '0;
    m_be = '0; m_own = 0; m_rsp = '0; m_rsp_data = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    s_vld[i] = v; s_addr[i] = a; s_wr[i] = w; s_data[i] = d; s_be[i] = '1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, 1'b0, '0);
    pend = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_vld[i]                 = s_vld[i];
      req_addr[i*AW +: AW]       = s_addr[i];
      req_wr_en[i]               = s_wr[i];
      req_wr_data[i*DW +: DW]    = s_data[i];
      req_wr_byte_en[i*BW +: BW] = s_be[i];
    end
  endtask

  // New random requests only on requesters not still waiting for acceptance
  task automatic gen();
    int sel;
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        sel       = $urandom_range(0, 9);
        s_vld[i]  = ($urandom_range(0, 9) < 6);
        s_addr[i] = (sel < 5) ? 32'h400 : (sel < 8) ? ($urandom | 32'h800) : 32'($urandom_range(0, 1023));
        s_wr[i]   = 1'($urandom);
        s_data[i] = $urandom;
        s_be[i]   = BW'($urandom);
        if (!allow_exit && s_addr[i] < 1024) s_data[i][0] = 1'b0;
      end
    end
  endtask

  task automatic step();
    int win;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    check("en", en, m_en);
    check("addr", addr, m_addr);
    check("wr_en", wr_en, m_wr);
    check("wr_data", wr_data, m_data);
    check("wr_byte_en", wr_byte_en, m_be);
    check("rsp_vld", rsp_vld, m_rsp);
    check("rsp_data", rsp_data, m_rsp_data);
    check("halted", halted, m_halt);
    apply();
    rd_data = $urandom;
    #1;
    win = -1;
    if (!m_halt) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && s_vld[i]) win = i;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_rdy", req_rdy, exp_rdy);
    m_rsp = '0;
    m_rsp_data = '0;
    if (m_en) begin
      m_rsp[m_own] = 1'b1;
      if (!m_wr) m_rsp_data = rd_data;
    end
    m_en = (win >= 0);
    if (win >= 0) begin
      m_addr = s_addr[win]; m_wr = s_wr[win]; m_data = s_data[win]; m_be = s_be[win];
      m_own  = win;
      m_ptr  = (win + 1) % N;
      if (s_wr[win] && s_addr[win] < 1024 && s_data[win][0]) m_halt = 1;
    end
    for (int i = 0; i < N; i++) pend[i] = s_vld[i] && (i != win);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_en", en, 1'b0);
    check("rst_rsp_vld", rsp_vld, '0);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", addr, '0);
    clear_all();
    apply();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    allow_exit = 0;
    rd_data = '0;
    clear_all();
    apply();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single read
    set_req(0, 1'b1, 32'h400, 1'b0, '0); step();
    clear_all(); step(); step();

    // Contention: two writers to the print byte
    set_req(0, 1'b1, 32'h400, 1'b1, 32'h41);
    set_req(1, 1'b1, 32'h400, 1'b1, 32'h42);
    repeat (6) step();
    clear_all(); step(); step();

    // Pointer hold across idle cycles
    set_req(1, 1'b1, 32'h404, 1'b0, '0); step();
    clear_all(); repeat (3) step();
    set_req(0, 1'b1, 32'h400, 1'b0, '0);
    set_req(1, 1'b1, 32'h408, 1'b0, '0);
    step();
    s_vld[0] = 1'b0; step();
    clear_all(); step(); step();

    // Non-exit command and print byte with bit 0 set
    set_req(0, 1'b1, 32'h10, 1'b1, 32'h2); step();
    clear_all(); set_req(1, 1'b1, 32'h400, 1'b1, 32'h1); step();
    clear_all(); step(); step();

    repeat (400) begin gen(); step(); end

    // Reset while en is high
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      gen(); step();
      if (m_en) found = 1;
    end
    check("reset_en_seen", 64'(found), 64'd1);
    @(posedge clk); #2;
    check("pre_reset_en", en, 1'b1);
    do_reset();
    step();

    // Exit on the top of the command window while req0 also waits
    set_req(0, 1'b1, 32'h400, 1'b0, '0); step();
    set_req(0, 1'b1, 32'h20, 1'b1, 32'h5);
    set_req(1, 1'b1, 32'h3FF, 1'b1, 32'h1);
    step();
    s_vld[1] = 1'b0;
    repeat (5) step();
    check("halt_hold", halted, 1'b1);

    @(negedge clk);
    do_reset();
    allow_exit = 1;
    repeat (300) begin gen(); step(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
